// File: rtl/od_line_arbiter.sv
// od_line_arbiter: grants one requester at a time to hold a shared open-drain line low.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration instead of lowest-index priority.
module od_line_arbiter #(
    parameter int NREQ      = 4,
    parameter int HOLD_CYC  = 8,
    parameter int GUARD_CYC = 2,
    parameter int IDW       = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            err_clr,
    input  logic            line_in,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            done,
    output logic            line_oe,
    output logic            busy,
    output logic            ext_low,
    output logic            readback_err
);
    localparam int CMAX = (HOLD_CYC > GUARD_CYC) ? HOLD_CYC : GUARD_CYC;
    localparam int CW   = $clog2(CMAX);

    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GUARD_LD = CW'(GUARD_CYC - 1);
    // Readback is trusted only once the synchronizer has seen our own drive.
    localparam logic [CW-1:0] CHK_FROM = CW'(HOLD_CYC - 3);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RELEASE
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_d;
    logic            sync1;
    logic            line_s;
    logic [NREQ-1:0] gnt_d;
    logic [IDW-1:0]  gnt_id_d;
    logic [IDW-1:0]  win;
    logic            win_vld;
    logic            done_d;
    logic            err_d;
    logic            grant_go;

    assign win_vld  = |req;
    assign grant_go = (state == IDLE) && win_vld && line_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] last_id;

    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(last_id) + 1 + i) % NREQ);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_id <= IDW'(NREQ - 1);
        end else if (grant_go) begin
            last_id <= win;
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win = IDW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        gnt_d    = gnt;
        gnt_id_d = gnt_id;
        done_d   = 1'b0;
        err_d    = readback_err && !err_clr;
        unique case (state)
            IDLE: begin
                if (grant_go) begin
                    state_d  = DRIVE;
                    cnt_d    = HOLD_LD;
                    gnt_d    = NREQ'(1) << win;
                    gnt_id_d = win;
                end
            end
            DRIVE: begin
                if (line_s && (cnt <= CHK_FROM)) begin
                    err_d = 1'b1;
                end
                if ((cnt == '0) || !req[gnt_id]) begin
                    state_d = RELEASE;
                    cnt_d   = GUARD_LD;
                    gnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            RELEASE: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sync1        <= 1'b1;
            line_s       <= 1'b1;
            gnt          <= '0;
            gnt_id       <= '0;
            done         <= 1'b0;
            ext_low      <= 1'b0;
            readback_err <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            sync1        <= line_in;
            line_s       <= sync1;
            gnt          <= gnt_d;
            gnt_id       <= gnt_id_d;
            done         <= done_d;
            ext_low      <= (state == IDLE) && !line_s;
            readback_err <= err_d;
        end
    end

    assign line_oe = (state == DRIVE);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_od_line_arbiter.sv
// Scoreboard bench for od_line_arbiter; expected grant ids are queued as
// stimulus is applied and popped when a grant appears on gnt.
module tb_od_line_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       err_clr;
    logic       line_in;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       done;
    logic       line_oe;
    logic       busy;
    logic       ext_low;
    logic       readback_err;

    logic       force_low = 1'b0;
    logic       stuck_hi  = 1'b0;
    int         checks    = 0;
    int         failures  = 0;
    logic [1:0] exp_q[$];
    logic [3:0] prev_gnt  = '0;

    od_line_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .err_clr      (err_clr),
        .line_in      (line_in),
        .gnt          (gnt),
        .gnt_id       (gnt_id),
        .done         (done),
        .line_oe      (line_oe),
        .busy         (busy),
        .ext_low      (ext_low),
        .readback_err (readback_err)
    );

    always #5 clk = ~clk;

    // Pad model: pull-up unless we drive low, a foreign device holds it, or it is stuck.
    assign line_in = force_low ? 1'b0 : (stuck_hi ? 1'b1 : ~line_oe);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk(tag, busy, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (gnt != 0 && prev_gnt == 0) begin
            if (exp_q.size() == 0) begin
                chk("unexp_gnt", gnt, 0);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                chk("sb_gnt_id", gnt_id, e);
                chk("sb_gnt", gnt, 4'b0001 << e);
            end
        end
        prev_gnt = gnt;
    end

    initial begin
        int t_start[4];
        int ng;
        int cyc;
        int n;
        logic was;

        rst     = 1'b1;
        req     = '0;
        err_clr = 1'b0;
        tick();
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_id", gnt_id, 0);
        chk("rst_oe", line_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ext", ext_low, 0);
        chk("rst_err", readback_err, 0);
        rst = 1'b0;
        tick();

        // Single full-length grant
        exp_q.push_back(2'd0);
        req = 4'b0001;
        tick();
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_oe1", line_oe, 1);
        for (int k = 2; k <= 8; k++) begin
            tick();
            chk("t1_oe", line_oe, 1);
            chk("t1_nodone", done, 0);
        end
        tick();
        chk("t1_rel_oe", line_oe, 0);
        chk("t1_done", done, 1);
        chk("t1_rel_busy", busy, 1);
        chk("t1_rel_gnt", gnt, 0);
        req = '0;
        tick();
        chk("t1_done_1cyc", done, 0);
        chk("t1_guard2", busy, 1);
        tick();
        chk("t1_idle", busy, 0);
        chk("t1_err", readback_err, 0);
        chk("t1_id_hold", gnt_id, 0);

        // Continuous contention between 1 and 3
`ifdef ARB_ROUND_ROBIN_EN
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
`else
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
`endif
        ng  = 0;
        cyc = 0;
        was = 1'b0;
        req = 4'b1010;
        while (ng < 4 && cyc < 80) begin
            tick();
            cyc++;
            if (gnt != 0 && !was) begin
                t_start[ng] = cyc;
                ng++;
                if (ng == 4) req = '0;
            end
            was = (gnt != 0);
        end
        chk("t2_count", ng, 4);
        for (int i = 1; i < ng; i++) begin
            chk("t2_period", t_start[i] - t_start[i-1], 11);
        end
        wait_idle("t2_idle");
        tick();

        // Foreign holder defers the grant
        force_low = 1'b1;
        tick();
        tick();
        req = 4'b0100;
        tick();
        chk("t3_ext", ext_low, 1);
        repeat (4) tick();
        chk("t3_nogrant", gnt, 0);
        chk("t3_ext_hold", ext_low, 1);
        exp_q.push_back(2'd2);
        force_low = 1'b0;
        n = 0;
        while (gnt == 0 && n < 6) begin
            tick();
            n++;
        end
        chk("t3_gnt", gnt, 4'b0100);
        chk("t3_lat", n <= 3, 1);
        req = '0;
        wait_idle("t3_idle");
        tick();

        // Line stuck high while driving
        stuck_hi = 1'b1;
        exp_q.push_back(2'd0);
        req = 4'b0001;
        tick();
        chk("t4_gnt", gnt, 4'b0001);
        tick();
        chk("t4_err_early", readback_err, 0);
        tick();
        tick();
        chk("t4_err_set", readback_err, 1);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("t4_done", done, 1);
        chk("t4_err_done", readback_err, 1);
        req = '0;
        wait_idle("t4_idle");
        chk("t4_err_hold", readback_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_err_clr", readback_err, 0);
        stuck_hi = 1'b0;
        tick();

        // Early release on the 4th drive cycle
        exp_q.push_back(2'd0);
        req = 4'b0001;
        repeat (4) tick();
        chk("t5_oe4", line_oe, 1);
        req = '0;
        tick();
        chk("t5_rel_oe", line_oe, 0);
        chk("t5_done", done, 1);
        chk("t5_gnt", gnt, 0);
        chk("t5_busy", busy, 1);
        tick();
        chk("t5_done_1cyc", done, 0);
        chk("t5_guard2", busy, 1);
        tick();
        chk("t5_idle", busy, 0);
        tick();

        // Reset in the middle of a drive
        exp_q.push_back(2'd0);
        req = 4'b0001;
        repeat (5) tick();
        chk("t6_oe5", line_oe, 1);
        rst = 1'b1;
        tick();
        chk("t6_oe", line_oe, 0);
        chk("t6_gnt", gnt, 0);
        chk("t6_done", done, 0);
        chk("t6_busy", busy, 0);
        exp_q.push_back(2'd0);
        rst = 1'b0;
        n = 0;
        while (gnt == 0 && n < 6) begin
            tick();
            n++;
        end
        chk("t6_regnt", gnt, 4'b0001);
        req = '0;
        wait_idle("t6_idle");
        tick();

        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/od_line_arbiter.md
Name: od_line_arbiter

Overview:
- Arbiter and sequencer for one shared open-drain bidirectional line, such as a wired-low button/LED pad.
- Up to NREQ internal requesters ask to pull the line low. The block grants one requester at a time and holds the line low for a bounded time.
- Between owners it inserts a released guard (turnaround) interval.
- It defers granting while an external device holds the line low, and flags readback mismatches.
- It sits between requester logic and the pad tristate: pad = line_oe ? 1'b0 : 1'bz, and line_in is the raw pad sample.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- HOLD_CYC, 8: cycles the line is driven low per grant; must be >= 3.
- GUARD_CYC, 2: cycles the line is released after each grant; must be >= 2 so the synchronizer sees the pull-up before the next grant.
- IDW, $clog2(NREQ): width of gnt_id.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  level request per requester.
- err_clr  in  1  clears readback_err (one-cycle pulse).
- line_in  in  1  raw pad sample, asynchronous to clk.
- gnt  out  NREQ  one-hot grant; all zero when no owner.
- gnt_id  out  IDW  index of the current or most recent owner.
- done  out  1  one-cycle pulse on the first cycle of RELEASE.
- line_oe  out  1  1 = drive pad low, 0 = high-Z.
- busy  out  1  1 in DRIVE or RELEASE.
- ext_low  out  1  line sampled low while in IDLE, meaning a foreign holder.
- readback_err  out  1  sticky; line seen high while driving low.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; gnt=0, gnt_id=0, done=0, line_oe=0, busy=0, ext_low=0, readback_err=0.
  - Synchronizer flops = 1; counter=0.
  - Reset mid-DRIVE releases line_oe on that same edge; no done pulse.
- line_in passes through a 2-flop synchronizer (line_s); latency 2 cycles.
- ext_low is registered: (state==IDLE && line_s==0).
- States:
  - IDLE:
    - If |req && line_s==1, select a winner. Next cycle: gnt[winner]=1, gnt_id=winner, line_oe=1, busy=1, counter=HOLD_CYC-1 -> DRIVE.
    - Grant latency is 1 cycle from req sampled high.
    - If line_s==0, no grant.
  - DRIVE:
    - line_oe=1.
    - Counter decrements each cycle.
    - From the 3rd DRIVE cycle onward, line_s==1 sets readback_err.
    - At counter==0, or if req[gnt_id] is sampled 0 (early release), go to RELEASE.
    - DRIVE length is exactly HOLD_CYC cycles unless released early.
  - RELEASE:
    - line_oe=0, gnt=0, done=1 for the first cycle only, busy=1.
    - counter=GUARD_CYC-1, decrementing; at 0 -> IDLE (busy=0).
    - Exactly GUARD_CYC cycles.
- Back-to-back grants: minimum period HOLD_CYC+GUARD_CYC+1 cycles (includes one IDLE cycle).
- Arbitration (default): fixed priority, lowest index wins.
- Requests arriving during DRIVE/RELEASE are only evaluated in IDLE. req is level, not latched; a dropped req is forgotten.
- readback_err:
  - Sticky until err_clr or rst.
  - If err_clr and a new error occur in the same cycle, set wins.
- gnt_id holds its value after release.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration. Search starts at (last_id+1) mod NREQ.
  - last_id updates on each grant and resets to NREQ-1, so the first search starts at index 0.
- Undefined: fixed lowest-index priority; no last_id register.

Test Plan:
- Reset, then req=4'b0001, line_in follows line_oe (0 when driven, else 1):
  - gnt=0001 one cycle later.
  - line_oe=1 for 8 cycles.
  - done pulses on cycle 9 with line_oe=0.
  - busy drops after 2 release cycles.
  - readback_err=0.
- req=4'b1010 held continuously:
  - Without the macro, index 1 wins every grant.
  - With ARB_ROUND_ROBIN_EN, grants alternate 1,3,1,3 with an 11-cycle period.
- line_in forced 0 while IDLE with req=4'b0100:
  - ext_low=1 after 3 cycles; no grant.
  - Release line_in=1 -> grant to index 2 within 3 cycles.
- line_in stuck 1 during DRIVE:
  - readback_err=1 on the 3rd DRIVE cycle and stays set after done.
  - err_clr pulse -> 0.
- req[0] dropped on the 4th DRIVE cycle:
  - RELEASE the next cycle; done pulses; 2 guard cycles, then IDLE.
- rst asserted on the 5th DRIVE cycle:
  - Next edge: line_oe=0, gnt=0, done=0, state IDLE.
  - With req still high after rst drops, a new grant follows after the synchronizer settles.
